// File: rtl/led_ctrl_pkg.sv
// Shared mode encoding, scan end points and the mode-stepping helper for led_mode_ctrl.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_SCAN   = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_MIRROR = 2'd3
    } mode_e;

    localparam logic [7:0] SCAN_FIRST = 8'h01;
    localparam logic [7:0] SCAN_LAST  = 8'h80;

    // Simultaneous forward and backward requests cancel out.
    function automatic mode_e mode_step(input mode_e cur, input logic fwd, input logic back);
        mode_e nxt;
        nxt = cur;
        if (fwd && !back) begin
            nxt = mode_e'(cur + 2'd1);
        end else if (back && !fwd) begin
            nxt = mode_e'(cur - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/led_mode_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, debounced level and
// a one-cycle pulse on each accepted rising level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    // The counter only runs while the synced input disagrees with the accepted level,
    // so any return to the old level restarts the stability window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// LED mode controller: counter / scanner / blink / switch-mirror patterns selected by
// two debounced buttons. Optional PWM dimming when LED_PWM_EN is defined.
module led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int TICK_DIV        = 3125000,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk_25mhz,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic [6:0] sw,
`ifdef LED_PWM_EN
    input  logic [2:0] brightness,
`endif
    output logic [7:0] led,
    output logic [1:0] mode
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

    logic              next_level;
    logic              next_press;
    logic              prev_level;
    logic              prev_press;

    logic              sw_s1_q;
    logic [6:0]        sw_sync1_q;
    logic [6:0]        sw_sync2_q;

    mode_e             mode_q;
    mode_e             mode_d;
    logic              mode_chg;

    logic [TICK_W-1:0] tick_cnt_q;
    logic [TICK_W-1:0] tick_cnt_d;
    logic              tick;

    logic [7:0]        count_q;
    logic [7:0]        count_d;
    logic [7:0]        scan_q;
    logic [7:0]        scan_d;
    logic              scan_up_q;
    logic              scan_up_d;
    logic              blink_q;
    logic              blink_d;

    logic [7:0]        pattern;
    logic [7:0]        led_q;
    logic [7:0]        led_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk_i   (clk_25mhz),
        .rst_ni  (rst_n),
        .btn_i   (btn_next),
        .level_o (next_level),
        .press_o (next_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
        .clk_i   (clk_25mhz),
        .rst_ni  (rst_n),
        .btn_i   (btn_prev),
        .level_o (prev_level),
        .press_o (prev_press)
    );

    always_ff @(posedge clk_25mhz) begin
        if (!rst_n) begin
            sw_s1_q    <= 1'b0;
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
        end else begin
            sw_s1_q    <= 1'b1;
            sw_sync1_q <= sw;
            sw_sync2_q <= sw_sync1_q;
        end
    end

    // Mode FSM: state register
    always_ff @(posedge clk_25mhz) begin
        if (!rst_n) begin
            mode_q <= MODE_COUNT;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Mode FSM: next state
    always_comb begin
        mode_d   = mode_q;
        mode_d   = mode_step(mode_q, next_press & next_level, prev_press & prev_level);
        mode_chg = (mode_d != mode_q);
    end

    assign tick = (tick_cnt_q == TICK_MAX);

    // A mode change restarts the prescaler and puts the new pattern at its entry value.
    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
        count_d    = count_q;
        scan_d     = scan_q;
        scan_up_d  = scan_up_q;
        blink_d    = blink_q;
        if (mode_chg) begin
            tick_cnt_d = '0;
            count_d    = 8'h00;
            scan_d     = SCAN_FIRST;
            scan_up_d  = 1'b1;
            blink_d    = 1'b0;
        end else if (tick) begin
            case (mode_q)
                MODE_COUNT: count_d = count_q + 8'd1;
                MODE_SCAN: begin
                    if (scan_q == SCAN_LAST) begin
                        scan_up_d = 1'b0;
                    end else if (scan_q == SCAN_FIRST) begin
                        scan_up_d = 1'b1;
                    end
                    scan_d = scan_up_d ? (scan_q << 1) : (scan_q >> 1);
                end
                MODE_BLINK: blink_d = ~blink_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            count_q    <= 8'h00;
            scan_q     <= SCAN_FIRST;
            scan_up_q  <= 1'b1;
            blink_q    <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            count_q    <= count_d;
            scan_q     <= scan_d;
            scan_up_q  <= scan_up_d;
            blink_q    <= blink_d;
        end
    end

    always_comb begin
        pattern = 8'h00;
        case (mode_q)
            MODE_COUNT:  pattern = count_q;
            MODE_SCAN:   pattern = scan_q;
            MODE_BLINK:  pattern = {8{blink_q}};
            MODE_MIRROR: pattern = {1'b0, sw_sync2_q & {7{sw_s1_q}}};
            default:     pattern = 8'h00;
        endcase
    end

`ifdef LED_PWM_EN
    logic [2:0] pwm_cnt_q;

    always_ff @(posedge clk_25mhz) begin
        if (!rst_n) begin
            pwm_cnt_q <= 3'd0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 3'd1;
        end
    end

    // On for pwm_cnt 0..brightness, giving (brightness+1)/8 duty.
    assign led_d = pattern & {8{pwm_cnt_q <= brightness}};
`else
    assign led_d = pattern;
`endif

    always_ff @(posedge clk_25mhz) begin
        if (!rst_n) begin
            led_q <= 8'h00;
        end else begin
            led_q <= led_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Self-checking bench for led_mode_ctrl with a closed-form reference model of the LED patterns.
module tb_led_mode_ctrl;

    localparam int TICK = 4;
    localparam int DEB  = 3;

    logic       clk_25mhz = 1'b0;
    logic       rst_n     = 1'b0;
    logic       btn_next  = 1'b0;
    logic       btn_prev  = 1'b0;
    logic [6:0] sw        = 7'h00;
    logic [7:0] led;
    logic [1:0] mode;
`ifdef LED_PWM_EN
    logic [2:0] brightness = 3'd7;
`endif

    led_mode_ctrl #(.TICK_DIV(TICK), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk_25mhz (clk_25mhz),
        .rst_n     (rst_n),
        .btn_next  (btn_next),
        .btn_prev  (btn_prev),
        .sw        (sw),
`ifdef LED_PWM_EN
        .brightness(brightness),
`endif
        .led       (led),
        .mode      (mode)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    int         checks    = 0;
    int         errors    = 0;
    int         cyc       = 0;
    int         entry     = 0;
    int         exp_mode  = 0;
    int         pend_e    = -1;
    int         pend_mode = 0;
    logic       rst_entry = 1'b1;
    logic       chk_led   = 1'b1;
    logic [6:0] sw_h [4];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Pattern value m edges after the mode was entered: n = number of ticks already applied.
    function automatic logic [7:0] model_led(input int md, input int m, input logic [6:0] swv);
        int n;
        int p;
        n = (m - 1) / TICK;
        case (md)
            0: return 8'(n % 256);
            1: begin
                p = n % 14;
                return 8'(1 << ((p <= 7) ? p : 14 - p));
            end
            2: return (n % 2 == 1) ? 8'hFF : 8'h00;
            default: return {1'b0, swv};
        endcase
    endfunction

    task automatic step();
        sw_h[(cyc + 1) % 4] = sw;
        @(posedge clk_25mhz);
        #1;
        cyc++;
        if (!rst_n) begin
            exp_mode  = 0;
            entry     = cyc;
            rst_entry = 1'b1;
            pend_e    = -1;
        end else if (cyc == pend_e) begin
            exp_mode  = pend_mode;
            entry     = cyc;
            rst_entry = 1'b0;
            pend_e    = -1;
        end
        chk("mode", {6'b0, mode}, 8'(exp_mode));
        if (chk_led) begin
            if (cyc - entry >= 1)
                chk("led", led, model_led(exp_mode, cyc - entry, sw_h[(cyc + 2) % 4]));
            else if (rst_entry)
                chk("led_rst", led, 8'h00);
        end
    endtask

    // Mode change lands 2 sync + DEB stable samples + 1 FSM edge after the first sampling edge.
    task automatic press(input logic nx, input logic pv, input int len);
        int a;
        a = cyc + 1;
        btn_next = nx;
        btn_prev = pv;
        if (len >= DEB && (nx ^ pv)) begin
            pend_e    = a + 2 + DEB;
            pend_mode = nx ? (exp_mode + 1) % 4 : (exp_mode + 3) % 4;
        end
        repeat (len) step();
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (DEB + 4) step();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        int guard;
        int kind;
        for (int i = 0; i < 4; i++) sw_h[i] = 7'h00;

        // Reset, then COUNT through a full wrap of the 8-bit counter
        rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(256 * TICK + 8);

        // Bounce is ignored; a real press enters SCAN and walks the bounce sequence
        press(1'b1, 1'b0, 2);
        press(1'b1, 1'b0, 6);
        run(30 * TICK);

        // Backward wrap 0->3, MIRROR, forward wrap 3->0, simultaneous presses
        press(1'b0, 1'b1, 6);
        press(1'b0, 1'b1, 6);
        chk("mode_wrap_back", {6'b0, mode}, 8'd3);
        sw = 7'h55;
        run(10);
        chk("mirror_55", led, 8'h55);
        press(1'b1, 1'b0, 6);
        chk("mode_wrap_fwd", {6'b0, mode}, 8'd0);
        press(1'b1, 1'b1, 6);
        chk("mode_both", {6'b0, mode}, 8'd0);
        press(1'b1, 1'b0, 4);
        press(1'b1, 1'b0, 5);
        run(6 * TICK);

        // Reset in the middle of SCAN while led shows 10
        press(1'b0, 1'b1, 6);
        guard = 0;
        while (!(cyc - entry >= 1 && exp_mode == 1 &&
                 model_led(exp_mode, cyc - entry, sw) == 8'h10) && guard < 200) begin
            step();
            guard++;
        end
        chk("scan_reach_10", led, 8'h10);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        run(5 * TICK);

        // Randomised buttons, bounces and switch values
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 4));
            sw   = 7'($urandom);
            case (kind)
                0: press(1'b1, 1'b0, int'($urandom_range(DEB, DEB + 6)));
                1: press(1'b0, 1'b1, int'($urandom_range(DEB, DEB + 6)));
                2: press(1'b1, 1'b1, int'($urandom_range(DEB, DEB + 6)));
                3: press(1'b1, 1'b0, int'($urandom_range(1, DEB - 1)));
                default: press(1'b0, 1'b1, int'($urandom_range(1, DEB - 1)));
            endcase
            run(int'($urandom_range(5, 60)));
        end

`ifdef LED_PWM_EN
        // Duty check on a static MIRROR pattern of 7F
        guard = 0;
        while (exp_mode != 3 && guard < 4) begin
            press(1'b1, 1'b0, 6);
            guard++;
        end
        sw = 7'h7F;
        run(6);
        chk_led = 1'b0;
        for (int b = 7; b >= 0; b -= 4) begin
            int on_cnt;
            brightness = 3'(b);
            run(2);
            on_cnt = 0;
            for (int k = 0; k < 8; k++) begin
                step();
                if (led == 8'h7F) on_cnt++;
            end
            chk("pwm_duty", 8'(on_cnt), 8'(b + 1));
        end
        brightness = 3'd0;
        run(2);
        begin
            int on_cnt;
            on_cnt = 0;
            for (int k = 0; k < 8; k++) begin
                step();
                if (led == 8'h7F) on_cnt++;
            end
            chk("pwm_duty0", 8'(on_cnt), 8'd1);
        end
        chk_led = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
